// File: rtl/i2s_audio_tx.sv
// I2S transmitter: latches a stereo PCM pair, serialises it MSB-first with the
// one-bit I2S delay, and issues a per-frame sample request / underrun flag.
module i2s_audio_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_BITS    = 32,
  parameter int MCLK_DIV     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_l,
  input  logic [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                    sample_valid,
  input  logic                    mute,
  output logic                    bclk,
  output logic                    lrck,
  output logic                    dac,
  output logic                    sample_req,
  output logic                    underrun
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int DW    = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
  localparam int PW    = $clog2(FRAME);
  localparam int PAD   = SLOT_BITS - 1 - SAMPLE_WIDTH;

  localparam logic [DW-1:0] DIV_LAST  = DW'(MCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(MCLK_DIV / 2);
  localparam logic [PW-1:0] POS_LAST  = PW'(FRAME - 1);
  localparam logic [PW-1:0] POS_RIGHT = PW'(SLOT_BITS);

  logic [DW-1:0]           r_div;
  logic [PW-1:0]           r_pos;
  logic [SAMPLE_WIDTH-1:0] r_hold_l, r_hold_r;
  logic [FRAME-1:0]        r_shift;
  logic                    r_fresh;
  logic                    r_bclk, r_lrck, r_dac, r_req, r_ur;

  logic                    w_div_wrap, w_pos_wrap, w_load;
  logic [DW-1:0]           w_div_nxt;
  logic [PW-1:0]           w_pos_nxt;
  logic [SLOT_BITS-1:0]    w_slot_l, w_slot_r;
  logic [FRAME-1:0]        w_frame;

  assign w_div_wrap = (r_div == DIV_LAST);
  assign w_pos_wrap = (r_pos == POS_LAST);
  assign w_load     = w_div_wrap && w_pos_wrap;

  assign w_div_nxt = w_div_wrap ? '0 : r_div + 1'b1;
  assign w_pos_nxt = !w_div_wrap ? r_pos : (w_pos_wrap ? '0 : r_pos + 1'b1);

  // Slot MSB stays 0 for the one-bit delay; sample sits MSB-justified below it.
  assign w_slot_l = SLOT_BITS'(r_hold_l) << PAD;
  assign w_slot_r = SLOT_BITS'(r_hold_r) << PAD;
  assign w_frame  = mute ? '0 : {w_slot_l, w_slot_r};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_pos    <= '0;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_shift  <= '0;
      r_fresh  <= 1'b0;
      r_bclk   <= 1'b0;
      r_lrck   <= 1'b0;
      r_dac    <= 1'b0;
      r_req    <= 1'b0;
      r_ur     <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_pos  <= w_pos_nxt;
      r_bclk <= (w_div_nxt >= DIV_HALF);
      r_lrck <= (w_pos_nxt >= POS_RIGHT);
      r_req  <= w_load;
      r_ur   <= w_load && !r_fresh;

      if (sample_valid) begin
        r_hold_l <= sample_l;
        r_hold_r <= sample_r;
      end

      // A strobe on the load cycle wins over the clear, so its data stays fresh.
      if (sample_valid)
        r_fresh <= 1'b1;
      else if (w_load)
        r_fresh <= 1'b0;

      // dac only moves on bclk fall (div wrap), so the DAC sees stable data on rise.
      if (w_load) begin
        r_shift <= w_frame;
        r_dac   <= w_frame[FRAME-1];
      end else if (w_div_wrap) begin
        r_shift <= r_shift << 1;
        r_dac   <= r_shift[FRAME-2];
      end
    end
  end

  assign bclk       = r_bclk;
  assign lrck       = r_lrck;
  assign dac        = r_dac;
  assign sample_req = r_req;
  assign underrun   = r_ur;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Scoreboard bench for i2s_audio_tx: a frame-level model pushes expected serial
// frames at each load; a monitor reassembles frames on bclk rises and compares.
module tb_i2s_audio_tx;
  localparam int SW = 16, SB = 32, MD = 4;
  localparam int FR = 2 * SB, FCLK = FR * MD;
  localparam logic [63:0] LR_EXP = {32'h0, 32'hFFFF_FFFF};

  logic          clk = 1'b0, reset = 1'b1;
  logic [SW-1:0] sample_l = '0, sample_r = '0;
  logic          sample_valid = 1'b0, mute = 1'b0;
  logic          bclk, lrck, dac, sample_req, underrun;

  i2s_audio_tx #(.SAMPLE_WIDTH(SW), .SLOT_BITS(SB), .MCLK_DIV(MD)) dut (
    .clk(clk), .reset(reset), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .mute(mute), .bclk(bclk), .lrck(lrck),
    .dac(dac), .sample_req(sample_req), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FR-1:0] bits;
    bit            ur;
  } exp_t;
  exp_t q[$];

  int errors = 0, checks = 0, frames = 0;
  int cyc = 0;
  logic [SW-1:0] m_l = '0, m_r = '0;
  bit m_fresh = 0, cur_mute = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected bit per frame position, written straight from the I2S slot rules.
  function automatic logic [FR-1:0] serial(input logic [SW-1:0] l, input logic [SW-1:0] r, input bit m);
    logic [FR-1:0] w;
    w = '0;
    if (!m)
      for (int p = 1; p <= SW; p++) begin
        w[FR-1-p]      = l[SW-p];
        w[FR-1-(SB+p)] = r[SW-p];
      end
    return w;
  endfunction

  task automatic tick(input bit sv, input logic [SW-1:0] l, input logic [SW-1:0] r);
    sample_valid = sv;
    sample_l     = l;
    sample_r     = r;
    mute         = cur_mute;
    @(posedge clk);
    if (cyc % FCLK == FCLK - 1) begin
      exp_t e;
      e.bits  = serial(m_l, m_r, cur_mute);
      e.ur    = !m_fresh;
      q.push_back(e);
      m_fresh = 0;
    end
    if (sv) begin
      m_l     = l;
      m_r     = r;
      m_fresh = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0);
  endtask

  task automatic to_mod(input int m);
    while (cyc % FCLK != m) tick(1'b0, '0, '0);
  endtask

  // Monitor state
  bit            act = 0, gur = 0, pb = 0;
  int            idx = 0, ncyc = 0, nhi = 0, idle_cnt = 0;
  logic [FR-1:0] cap = '0, lrc = '0;

  task automatic check_frame();
    exp_t e;
    if (q.size() == 0) begin
      chk("queue_empty", 64'd1, 64'd0);
    end else begin
      e = q.pop_front();
      frames++;
      chk("dac_frame", cap, e.bits);
      chk("underrun", {63'd0, gur}, {63'd0, e.ur});
      chk("lrck_frame", lrc, LR_EXP);
      chk("bclk_rises", idx, 64'd64);
      chk("frame_clks", ncyc, 64'd256);
      chk("bclk_high", nhi, 64'd128);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      act      = 0;
      pb       = 0;
      idle_cnt = 0;
    end else begin
      idle_cnt++;
      if (idle_cnt > 2 * FCLK) begin
        chk("req_timeout", 64'd0, 64'd1);
        idle_cnt = 0;
      end
      if (sample_req) begin
        idle_cnt = 0;
        if (act) check_frame();
        act  = 1;
        idx  = 0;
        ncyc = 0;
        nhi  = 0;
        cap  = '0;
        lrc  = '0;
        gur  = underrun;
      end
      if (act) begin
        ncyc++;
        if (bclk) nhi++;
        if (bclk && !pb) begin
          if (idx < FR) begin
            cap[FR-1-idx] = dac;
            lrc[FR-1-idx] = lrck;
          end
          idx++;
        end
      end
      pb = bclk;
    end
  end

  initial begin
    bit early;
    #12;
    chk("rst_bclk", {63'd0, bclk}, 64'd0);
    chk("rst_lrck", {63'd0, lrck}, 64'd0);
    chk("rst_dac", {63'd0, dac}, 64'd0);
    chk("rst_req", {63'd0, sample_req}, 64'd0);
    chk("rst_ur", {63'd0, underrun}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;

    idle(2 * FCLK);                          // idle frames: zeros + underrun
    tick(1'b1, 16'h8001, 16'h7FFE);
    to_mod(FCLK - 1);
    tick(1'b1, 16'h1234, 16'h5678);          // strobe on the load cycle
    idle(100);
    tick(1'b1, 16'hFFFF, 16'hFFFF);
    cur_mute = 1;
    to_mod(FCLK - 1);
    tick(1'b0, '0, '0);                      // muted load
    idle(10);
    cur_mute = 0;
    to_mod(FCLK - 1);
    tick(1'b0, '0, '0);                      // retransmit FFFF, underrun
    idle(50);
    tick(1'b1, 16'h0001, 16'h0001);
    idle(30);
    tick(1'b1, 16'h0002, 16'h0002);
    to_mod(FCLK - 1);
    tick(1'b0, '0, '0);

    for (int i = 0; i < 20 * FCLK; i++) begin
      if ($urandom_range(0, 999) == 0) cur_mute = !cur_mute;
      if ($urandom_range(0, 299) == 0 || (cyc % FCLK == FCLK - 1 && $urandom_range(0, 3) == 0))
        tick(1'b1, SW'($urandom), SW'($urandom));
      else
        tick(1'b0, '0, '0);
    end
    cur_mute = 0;
    idle(FCLK);

    // Mid-frame reset at pos 20 (bclk high phase)
    to_mod(20 * MD + 2);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_bclk", {63'd0, bclk}, 64'd0);
    chk("mid_rst_lrck", {63'd0, lrck}, 64'd0);
    chk("mid_rst_dac", {63'd0, dac}, 64'd0);
    chk("mid_rst_req", {63'd0, sample_req}, 64'd0);
    q.delete();
    m_l = '0; m_r = '0; m_fresh = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;
    early = 0;
    for (int i = 0; i < FCLK - 1; i++) begin
      tick(1'b0, '0, '0);
      if (sample_req) early = 1;
    end
    chk("req_early", {63'd0, early}, 64'd0);
    tick(1'b0, '0, '0);
    chk("first_req", {63'd0, sample_req}, 64'd1);
    chk("first_ur", {63'd0, underrun}, 64'd1);
    idle(100);
    tick(1'b1, 16'hA5C3, 16'h3C5A);
    idle(3 * FCLK);
    chk("frames_seen", {63'd0, frames >= 25}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
